// File: rtl/cpu_writeback_if.sv
// Producer-side result handshake for the writeback block.
// The producer (master) offers a destination index and value; the
// writeback block (slave) answers with o_ready while it has FIFO room.
interface cpu_writeback_if;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_rd_idx;
    logic [31:0] i_rd_value;

    modport master (
        output i_valid,
        output i_rd_idx,
        output i_rd_value,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_rd_idx,
        input  i_rd_value,
        output o_ready
    );
endinterface

// File: rtl/cpu_writeback.sv
// Writeback commit stage: results are queued in an in-order FIFO and
// retired one per cycle into a registered output stage (o_inst_rd/o_rd),
// with o_tag counting register-file writes. Pending FIFO entries and the
// freshly committed output stage are visible to a combinational
// forwarding lookup on two read ports.
module cpu_writeback #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    cpu_writeback_if.slave             io_push,
    input  logic                       i_hold,
    output logic [TAG_WIDTH-1:0]       o_tag,
    output logic [4:0]                 o_inst_rd,
    output logic [31:0]                o_rd,
    input  logic [4:0]                 i_query_rs1,
    input  logic [4:0]                 i_query_rs2,
    output logic                       o_fwd1_hit,
    output logic                       o_fwd2_hit,
    output logic [31:0]                o_fwd1_value,
    output logic [31:0]                o_fwd2_value,
    output logic [$clog2(DEPTH):0]     o_pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage; validity is tracked by r_count, so the array itself
    // never needs clearing.
    logic [4:0]           r_mem_idx [DEPTH];
    logic [31:0]          r_mem_val [DEPTH];

    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    // Output stage and its one-cycle freshness flag
    logic [TAG_WIDTH-1:0] r_tag;
    logic [4:0]           r_out_idx;
    logic [31:0]          r_out_val;
    logic                 r_fresh;

    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;

    // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
    assign w_ready        = (r_count < CNT_W'(DEPTH));
    assign io_push.o_ready = w_ready;
    assign w_push         = io_push.i_valid && w_ready;
    assign w_pop          = !i_hold && (r_count != '0);

    assign o_tag     = r_tag;
    assign o_inst_rd = r_out_idx;
    assign o_rd      = r_out_val;
    assign o_pending = r_count;

    // Store accepted results at the write pointer.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem_idx[r_wr_ptr] <= io_push.i_rd_idx;
            r_mem_val[r_wr_ptr] <= io_push.i_rd_value;
        end
    end

    // Pointers, occupancy, commit into the output stage and tag counting.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_tag     <= '0;
            r_out_idx <= '0;
            r_out_val <= '0;
            r_fresh   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_tag     <= r_tag + 1'b1;
                r_out_idx <= r_mem_idx[r_rd_ptr];
                r_out_val <= r_mem_val[r_rd_ptr];
            end
            r_fresh <= w_pop;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Forwarding lookup: fresh output stage is the fallback, then FIFO
    // entries are scanned oldest to youngest so the youngest match wins.
    always_comb begin
        o_fwd1_hit   = 1'b0;
        o_fwd1_value = '0;
        o_fwd2_hit   = 1'b0;
        o_fwd2_value = '0;

        if (r_fresh && (i_query_rs1 != 5'd0) && (r_out_idx == i_query_rs1)) begin
            o_fwd1_hit   = 1'b1;
            o_fwd1_value = r_out_val;
        end
        if (r_fresh && (i_query_rs2 != 5'd0) && (r_out_idx == i_query_rs2)) begin
            o_fwd2_hit   = 1'b1;
            o_fwd2_value = r_out_val;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < r_count) begin
                if ((i_query_rs1 != 5'd0) &&
                    (r_mem_idx[r_rd_ptr + PTR_W'(i)] == i_query_rs1)) begin
                    o_fwd1_hit   = 1'b1;
                    o_fwd1_value = r_mem_val[r_rd_ptr + PTR_W'(i)];
                end
                if ((i_query_rs2 != 5'd0) &&
                    (r_mem_idx[r_rd_ptr + PTR_W'(i)] == i_query_rs2)) begin
                    o_fwd2_hit   = 1'b1;
                    o_fwd2_value = r_mem_val[r_rd_ptr + PTR_W'(i)];
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_writeback.sv
// Testbench for cpu_writeback: directed scenarios plus randomized traffic,
// with a queue-based reference model and a commit scoreboard.
module tb_cpu_writeback;

    localparam int DEPTH = 4;
    localparam int TW    = 4;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] val;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              hold;
    logic [4:0]        q1, q2;
    logic [TW-1:0]     o_tag;
    logic [4:0]        o_inst_rd;
    logic [31:0]       o_rd;
    logic              o_fwd1_hit, o_fwd2_hit;
    logic [31:0]       o_fwd1_value, o_fwd2_value;
    logic [$clog2(DEPTH):0] o_pending;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_writeback_if bus();

    cpu_writeback #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .io_push      (bus),
        .i_hold       (hold),
        .o_tag        (o_tag),
        .o_inst_rd    (o_inst_rd),
        .o_rd         (o_rd),
        .i_query_rs1  (q1),
        .i_query_rs2  (q2),
        .o_fwd1_hit   (o_fwd1_hit),
        .o_fwd2_hit   (o_fwd2_hit),
        .o_fwd1_value (o_fwd1_value),
        .o_fwd2_value (o_fwd2_value),
        .o_pending    (o_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t          m_q[$];
    ent_t          sb_q[$];
    logic [TW-1:0] m_tag   = '0;
    ent_t          m_out   = '0;
    bit            m_fresh = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (!rst_n) begin
            m_q.delete();
            sb_q.delete();
            m_tag   = '0;
            m_out   = '0;
            m_fresh = 1'b0;
        end else begin
            do_pop  = !hold && (m_q.size() > 0);
            do_push = bus.i_valid && (m_q.size() < DEPTH);
            m_fresh = do_pop;
            if (do_pop) begin
                m_out = m_q.pop_front();
                m_tag = m_tag + 1'b1;
            end
            if (do_push) begin
                e.idx = bus.i_rd_idx;
                e.val = bus.i_rd_value;
                m_q.push_back(e);
                sb_q.push_back(e);
            end
        end
    end

    function automatic void fwd_model(input logic [4:0] q, output logic hit, output logic [31:0] v);
        hit = 1'b0;
        v   = '0;
        if (q != 5'd0) begin
            for (int i = m_q.size() - 1; i >= 0; i--) begin
                if (m_q[i].idx == q) begin
                    hit = 1'b1;
                    v   = m_q[i].val;
                    return;
                end
            end
            if (m_fresh && m_out.idx == q) begin
                hit = 1'b1;
                v   = m_out.val;
            end
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [TW-1:0] mon_tag = '0;
    logic [TW-1:0] mon_next;

    always @(negedge clk) begin
        ent_t        e;
        logic        eh;
        logic [31:0] ev;
        if (!rst_n) begin
            mon_tag = '0;
        end else if (o_tag !== mon_tag) begin
            mon_next = mon_tag + 1'b1;
            check("tag_step", o_tag, mon_next);
            if (sb_q.size() == 0) begin
                check("spurious_commit", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("commit_rd", o_inst_rd, e.idx);
                check("commit_val", o_rd, e.val);
            end
            mon_tag = o_tag;
        end
        check("pending", o_pending, m_q.size());
        check("ready", bus.o_ready, (m_q.size() < DEPTH) ? 32'd1 : 32'd0);
        check("tag_model", o_tag, m_tag);
        check("out_rd_model", o_inst_rd, m_out.idx);
        check("out_val_model", o_rd, m_out.val);
        fwd_model(q1, eh, ev);
        check("fwd1_hit", o_fwd1_hit, eh);
        check("fwd1_val", o_fwd1_value, ev);
        fwd_model(q2, eh, ev);
        check("fwd2_hit", o_fwd2_hit, eh);
        check("fwd2_val", o_fwd2_value, ev);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [4:0] idx, input logic [31:0] val);
        bus.i_valid    = v;
        bus.i_rd_idx   = idx;
        bus.i_rd_value = val;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        hold        = 1'b0;
        #1;
        check("rst_pending_async", o_pending, 0);
        check("rst_tag_async", o_tag, 0);
        @(posedge clk);
        #1;
        check("rst_pending", o_pending, 0);
        check("rst_ready", bus.o_ready, 1);
        check("rst_tag", o_tag, 0);
        check("rst_inst_rd", o_inst_rd, 0);
        check("rst_rd", o_rd, 0);
        check("rst_fwd1", o_fwd1_hit, 0);
        check("rst_fwd2", o_fwd2_hit, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int            ncommit;
        logic [TW-1:0] prev, t0, t1, t2;
        int            waited;

        bus.i_valid    = 1'b0;
        bus.i_rd_idx   = '0;
        bus.i_rd_value = '0;
        hold           = 1'b0;
        q1             = 5'd5;
        q2             = 5'd7;
        rst_n          = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single write and one-cycle forwarding from the output stage
        q1 = 5'd5;
        step(1'b1, 5'd5, 32'hDEADBEEF);
        step(1'b0, 5'd0, 32'h0);
        check("single_tag", o_tag, 1);
        check("single_rd", o_inst_rd, 5);
        check("single_val", o_rd, 32'hDEADBEEF);
        check("single_fwd_hit", o_fwd1_hit, 1);
        check("single_fwd_val", o_fwd1_value, 32'hDEADBEEF);
        step(1'b0, 5'd0, 32'h0);
        check("single_fwd_gone", o_fwd1_hit, 0);
        check("single_tag_stable", o_tag, 1);

        // Fill under hold, then drain; a push while full is refused
        do_reset();
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'hA0 + i);
        bus.i_valid = 1'b0;
        check("full_ready", bus.o_ready, 0);
        check("full_pending", o_pending, 4);
        check("full_tag", o_tag, 0);
        hold = 1'b0;
        step(1'b1, 5'd9, 32'h99);
        check("drain_tag_1", o_tag, 1);
        check("drain_rd_1", o_inst_rd, 1);
        check("drain_pending_1", o_pending, 3);
        for (int i = 2; i <= 4; i++) begin
            step(1'b0, 5'd0, 32'h0);
            check("drain_tag", o_tag, i);
            check("drain_rd", o_inst_rd, i);
            check("drain_val", o_rd, 32'hA0 + i);
        end
        step(1'b0, 5'd0, 32'h0);
        check("full_push_dropped", o_tag, 4);
        check("drain_empty", o_pending, 0);

        // Tag wrap over 17 commits
        do_reset();
        ncommit = 0;
        prev = o_tag;
        t0 = '0; t1 = '0; t2 = '0;
        for (int c = 0; c < 40; c++) begin
            step((c < 17) ? 1'b1 : 1'b0, 5'(c + 1), 32'(c));
            if (o_tag != prev) begin
                ncommit++;
                t2 = t1; t1 = t0; t0 = o_tag;
                prev = o_tag;
            end
        end
        check("wrap_count", ncommit, 17);
        check("wrap_t15", t2, 15);
        check("wrap_t0", t1, 0);
        check("wrap_t1", t0, 1);

        // Forwarding priority: youngest of two pending writes to x7
        do_reset();
        hold = 1'b1;
        step(1'b1, 5'd7, 32'h11);
        step(1'b1, 5'd7, 32'h22);
        bus.i_valid = 1'b0;
        q1 = 5'd0;
        q2 = 5'd7;
        #1;
        check("prio_hit", o_fwd2_hit, 1);
        check("prio_val", o_fwd2_value, 32'h22);
        check("q0_hit", o_fwd1_hit, 0);
        check("q0_val", o_fwd1_value, 0);

        // x0 entry commits and bumps the tag but never forwards
        hold = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'h0);
        check("pre_x0_tag", o_tag, 2);
        step(1'b1, 5'd0, 32'h55);
        step(1'b0, 5'd0, 32'h0);
        check("x0_tag", o_tag, 3);
        check("x0_rd", o_inst_rd, 0);
        check("x0_val", o_rd, 32'h55);
        check("x0_fwd", o_fwd1_hit, 0);

        // Mid-run reset discards queued entries
        hold = 1'b1;
        for (int i = 1; i <= 3; i++) step(1'b1, 5'(i + 10), 32'hC0 + i);
        bus.i_valid = 1'b0;
        check("mid_pending", o_pending, 3);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 5'd0, 32'h0);
            check("post_rst_tag", o_tag, 0);
            check("post_rst_pending", o_pending, 0);
        end

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) do_reset();
            hold = ($urandom_range(0, 3) == 0);
            q1   = 5'($urandom_range(0, 7));
            q2   = 5'($urandom_range(0, 7));
            step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom);
        end

        // Drain with a bounded wait
        hold = 1'b0;
        bus.i_valid = 1'b0;
        waited = 0;
        while (sb_q.size() != 0 && waited < 50) begin
            step(1'b0, 5'd0, 32'h0);
            waited++;
        end
        check("drain_timeout", sb_q.size(), 0);
        step(1'b0, 5'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
